// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_pkg + alu_exec_unit
//
// Execute-stage ALU. One-cycle arithmetic/logic ops, iterative shifter that
// retires up to SHIFT_STEP bits per cycle. Produces the result and the
// ZF/SF/OF/CF flags consumed by the branch unit.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operation offered
//   in_ready   out  1      unit can accept (high only in IDLE)
//   aluctr     in   alu_t  operation code from alu_control
//   op_a       in   XLEN   operand A (rs1/PC)
//   op_b       in   XLEN   operand B (rs2/imm); shift amount in low bits
//   out_valid  out  1      result/flags valid (DONE)
//   out_ready  in   1      consumer accepts result
//   result     out  XLEN   ALU result
//   zf/sf/of/cf out 1      zero / sign / signed-overflow / carry-borrow
//   illegal    out  1      aluctr was ALU_UNDEFINED or an unknown code
//   dbg_state  out  2      current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; an output transfer happens on a rising edge where
// out_valid && out_ready. A producer may not retract its valid before the
// transfer; ready never depends combinationally on the partner's valid.
// ---------------------------------------------------------------------------
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD       = 4'd0,
    ALU_SUB       = 4'd1,
    ALU_AND       = 4'd2,
    ALU_OR        = 4'd3,
    ALU_XOR       = 4'd4,
    ALU_SLT       = 4'd5,
    ALU_SLTU      = 4'd6,
    ALU_SLL       = 4'd7,
    ALU_SRL       = 4'd8,
    ALU_SRA       = 4'd9,
    ALU_UNDEFINED = 4'd10
  } alu_t;
endpackage

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_t            aluctr,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            of,
  output logic            cf,
  output logic            illegal,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN is still representable.
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_q,   state_d;
  alu_t            kind_q,    kind_d;
  logic [XLEN-1:0] shreg_q,   shreg_d;
  logic [SHW:0]    rem_q,     rem_d;
  logic [XLEN-1:0] result_q,  result_d;
  logic            zf_q,      zf_d;
  logic            sf_q,      sf_d;
  logic            of_q,      of_d;
  logic            cf_q,      cf_d;
  logic            illegal_q, illegal_d;

  // -------------------------------------------------------------------------
  // Single-cycle arithmetic
  // -------------------------------------------------------------------------
  logic [XLEN:0] add_full;
  logic [XLEN:0] sub_full;
  logic          add_of;
  logic          sub_of;
  logic          slt;
  logic          sltu;

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  // Bit XLEN of the widened difference is the borrow, i.e. unsigned a < b.
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};
  // Overflow: operands of equal sign (ADD) / opposite sign (SUB) produce
  // a result whose sign differs from op_a.
  assign add_of   = (op_a[XLEN-1] == op_b[XLEN-1]) &&
                    (add_full[XLEN-1] != op_a[XLEN-1]);
  assign sub_of   = (op_a[XLEN-1] != op_b[XLEN-1]) &&
                    (sub_full[XLEN-1] != op_a[XLEN-1]);
  assign slt      = $signed(op_a) < $signed(op_b);
  assign sltu     = op_a < op_b;

  // -------------------------------------------------------------------------
  // Iterative shifter. In IDLE it works directly on the incoming operands so
  // the first step happens on the accept edge; in SHIFT it continues from the
  // partially shifted register. A shift of k steps therefore presents its
  // result k cycles after acceptance, and a zero-amount shift degenerates to
  // a one-cycle pass-through of op_a.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] sh_src;
  logic [SHW:0]    sh_rem;
  alu_t            sh_kind;
  logic [SHW:0]    sh_step;
  logic [XLEN-1:0] sh_out;
  logic [SHW:0]    sh_rem_next;

  always_comb begin
    if (state_q == S_IDLE) begin
      sh_src  = op_a;
      sh_rem  = {1'b0, op_b[SHW-1:0]};  // upper bits of op_b ignored
      sh_kind = aluctr;
    end else begin
      sh_src  = shreg_q;
      sh_rem  = rem_q;
      sh_kind = kind_q;
    end
    sh_step = (sh_rem < STEP) ? sh_rem : STEP;
    case (sh_kind)
      ALU_SLL: sh_out = sh_src << sh_step;
      ALU_SRA: sh_out = $signed(sh_src) >>> sh_step;
      default: sh_out = sh_src >> sh_step;
    endcase
    sh_rem_next = sh_rem - sh_step;
  end

  // -------------------------------------------------------------------------
  // Opcode decode for an operation presented in IDLE
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] res_c;
  logic            cf_c;
  logic            of_c;
  logic            ill_c;
  logic            is_shift_c;

  always_comb begin
    res_c      = '0;
    cf_c       = 1'b0;
    of_c       = 1'b0;
    ill_c      = 1'b0;
    is_shift_c = 1'b0;
    case (aluctr)
      ALU_ADD: begin
        res_c = add_full[XLEN-1:0];
        cf_c  = add_full[XLEN];
        of_c  = add_of;
      end
      ALU_SUB: begin
        res_c = sub_full[XLEN-1:0];
        cf_c  = sub_full[XLEN];
        of_c  = sub_of;
      end
      ALU_AND:  res_c = op_a & op_b;
      ALU_OR:   res_c = op_a | op_b;
      ALU_XOR:  res_c = op_a ^ op_b;
      ALU_SLT:  res_c = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU: res_c = {{(XLEN-1){1'b0}}, sltu};
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        res_c      = sh_out;
        is_shift_c = 1'b1;
      end
      // ALU_UNDEFINED and any unassigned encoding: result stays 0 (so zf=1).
      default:  ill_c = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM next-state and datapath register updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    shreg_d   = shreg_q;
    rem_d     = rem_q;
    result_d  = result_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    cf_d      = cf_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift_c && (sh_rem_next != '0)) begin
            state_d = S_SHIFT;
            kind_d  = aluctr;
            shreg_d = sh_out;
            rem_d   = sh_rem_next;
          end else begin
            state_d   = S_DONE;
            result_d  = res_c;
            zf_d      = (res_c == '0);
            sf_d      = res_c[XLEN-1];
            of_d      = of_c;
            cf_d      = cf_c;
            illegal_d = ill_c;
          end
        end
      end

      S_SHIFT: begin
        shreg_d = sh_out;
        rem_d   = sh_rem_next;
        if (sh_rem_next == '0) begin
          state_d   = S_DONE;
          result_d  = sh_out;
          zf_d      = (sh_out == '0);
          sf_d      = sh_out[XLEN-1];
          of_d      = 1'b0;
          cf_d      = 1'b0;
          illegal_d = 1'b0;
        end
      end

      // Result and flags are held untouched until the consumer takes them.
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kind_q    <= ALU_ADD;
      shreg_q   <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      cf_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      cf_q      <= cf_d;
      illegal_q <= illegal_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign cf        = cf_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

endmodule
